// File: rtl/dead_time_pkg.sv
// Shared state type and constants for the complementary dead-time generator.
package dead_time_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        DEAD  = 2'd1,
        ON_HI = 2'd2,
        ON_LO = 2'd3
    } dt_state_t;

    // Smallest dead interval; a programmed count of 0 is promoted to this.
    localparam int DT_MIN = 1;

endpackage

// File: rtl/dead_time_ch.sv
// One complementary channel: OFF/DEAD/ON_HI/ON_LO state machine plus the
// dead-interval down-counter. Gate outputs are flops decoded from next state.
module dead_time_ch
    import dead_time_pkg::*;
#(
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic [DT_W-1:0] dt_cycles,
    input  logic            pwm,
    output logic            s,
    output logic            nots,
    output dt_state_t       state
);

    localparam logic [DT_W-1:0] CNT_MIN = DT_W'(DT_MIN);

    dt_state_t       state_next;
    logic [DT_W-1:0] cnt;
    logic [DT_W-1:0] cnt_next;
    logic [DT_W-1:0] dt_load;
    logic            cmd_q;
    logic            cmd_next;

    // dt_cycles is only looked at here, i.e. at the moment the counter loads.
    assign dt_load = (dt_cycles < CNT_MIN) ? CNT_MIN : dt_cycles;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cmd_next   = cmd_q;
        if (!run) begin
            state_next = OFF;
            cnt_next   = '0;
        end else begin
            case (state)
                OFF: begin
                    state_next = DEAD;
                    cnt_next   = dt_load;
                    cmd_next   = pwm;
                end
                DEAD: begin
                    // Any command change restarts the whole interval.
                    if (pwm != cmd_q) begin
                        cnt_next = dt_load;
                        cmd_next = pwm;
                    end else if (cnt == CNT_MIN) begin
                        state_next = cmd_q ? ON_HI : ON_LO;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt - CNT_MIN;
                    end
                end
                ON_HI: begin
                    if (!pwm) begin
                        state_next = DEAD;
                        cnt_next   = dt_load;
                        cmd_next   = 1'b0;
                    end
                end
                ON_LO: begin
                    if (pwm) begin
                        state_next = DEAD;
                        cnt_next   = dt_load;
                        cmd_next   = 1'b1;
                    end
                end
                default: begin
                    state_next = OFF;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OFF;
            cnt   <= '0;
            cmd_q <= 1'b0;
            s     <= 1'b0;
            nots  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            cmd_q <= cmd_next;
            s     <= (state_next == ON_HI);
            nots  <= (state_next == ON_LO);
        end
    end

endmodule

// File: rtl/dead_time_gen.sv
// N-channel complementary gate-drive generator with counted dead time.
// Optional fault latch compiled in with `define DEAD_TIME_FAULT_EN.
module dead_time_gen
    import dead_time_pkg::*;
#(
    parameter int N_CH = 1,
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [DT_W-1:0] dt_cycles,
    input  logic [N_CH-1:0] pwm_in,
`ifdef DEAD_TIME_FAULT_EN
    input  logic            fault,
    input  logic            fault_clr,
    output logic            fault_lat,
`endif
    output logic [N_CH-1:0] s,
    output logic [N_CH-1:0] nots,
    output logic [N_CH-1:0] dt_busy
);

    logic      run;
    dt_state_t ch_state [N_CH];

`ifdef DEAD_TIME_FAULT_EN
    // fault wins over fault_clr; the live fault also blocks the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_lat <= 1'b0;
        end else if (fault) begin
            fault_lat <= 1'b1;
        end else if (fault_clr) begin
            fault_lat <= 1'b0;
        end
    end

    assign run = en & ~fault & ~fault_lat;
`else
    assign run = en;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        dead_time_ch #(
            .DT_W (DT_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .run       (run),
            .dt_cycles (dt_cycles),
            .pwm       (pwm_in[i]),
            .s         (s[i]),
            .nots      (nots[i]),
            .state     (ch_state[i])
        );

        assign dt_busy[i] = (ch_state[i] == DEAD);
    end

endmodule
